// File: rtl/bcd_mmss_timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bcd_mmss_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_UNIT = 4'd9;
  localparam bcd_t BCD_MAX_TENS = 4'd5;

  // Preset layout is {min_t, min_u, sec_t, sec_u}; both tens digits are capped at 5.
  function automatic logic bcd_load_ok(input logic [15:0] v);
    return (v[15:12] <= BCD_MAX_TENS) && (v[11:8] <= BCD_MAX_UNIT) &&
           (v[7:4]   <= BCD_MAX_TENS) && (v[3:0]  <= BCD_MAX_UNIT);
  endfunction

endpackage

// File: rtl/bcd_mmss_timer_digit_cnt.sv
// One BCD digit of the timer: wraps at max_val going up, at 0 going down.
// Latency: digit updates 1 cycle after clr/load/step_en; co is combinational.
// Backpressure: none; clr beats load, load beats step.
// Ports: clk, rst_n; clr, step_en, dir_down (1 = count down), max_val,
//        load, load_val in; dig (registered digit), co (carry/borrow out) out.
module bcd_digit_cnt
  import bcd_mmss_timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step_en,
  input  logic dir_down,
  input  bcd_t max_val,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t dig,
  output logic co
);

  // Combinational so a step ripples through all four digits in one cycle.
  assign co = step_en && (dir_down ? (dig == 4'd0) : (dig == max_val));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig <= 4'd0;
    end else if (clr) begin
      dig <= 4'd0;
    end else if (load) begin
      dig <= load_val;
    end else if (step_en) begin
      if (dir_down) dig <= (dig == 4'd0) ? max_val : dig - 4'd1;
      else          dig <= (dig == max_val) ? 4'd0 : dig + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mmss_timer.sv
// mm:ss stopwatch / countdown timer driving four BCD digit codes.
// Latency: outputs registered, 1 cycle after the sampled event (3 with BCD_MMSS_TIMER_SYNC_EN).
// Backpressure: none; buttons are levels, rising edges act once, load acts each cycle high.
// Ports: clk, rst_n; btn_ss_i, btn_clr_i, mode_down_i, load_i, load_val_i[15:0] in;
//        dig0_o..dig3_o (sec_u, sec_t, min_u, min_t), running_o, done_o,
//        wrap_o, load_err_o out.
// Build option: define BCD_MMSS_TIMER_SYNC_EN to put a 2-flop synchronizer on
//        btn_ss_i, btn_clr_i and load_i.
module bcd_mmss_timer
  import bcd_mmss_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_ss_i,
  input  logic        btn_clr_i,
  input  logic        mode_down_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic [3:0]  dig0_o,
  output logic [3:0]  dig1_o,
  output logic [3:0]  dig2_o,
  output logic [3:0]  dig3_o,
  output logic        running_o,
  output logic        done_o,
  output logic        wrap_o,
  output logic        load_err_o
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);

  logic ss_in, clr_in, load_in;

`ifdef BCD_MMSS_TIMER_SYNC_EN
  logic [1:0] ss_sync, clr_sync, load_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= 2'b00;
      clr_sync  <= 2'b00;
      load_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[0], btn_ss_i};
      clr_sync  <= {clr_sync[0], btn_clr_i};
      load_sync <= {load_sync[0], load_i};
    end
  end
  assign ss_in   = ss_sync[1];
  assign clr_in  = clr_sync[1];
  assign load_in = load_sync[1];
`else
  assign ss_in   = btn_ss_i;
  assign clr_in  = btn_clr_i;
  assign load_in = load_i;
`endif

  state_t           state;
  logic [CNT_W-1:0] presc;
  logic             mode_down_q;
  logic             ss_prev, clr_prev;
  bcd_t             d0, d1, d2, d3;
  logic             c0, c1, c2, c3;

  logic ss_ev, clr_ev, tick, step, load_take, load_apply, all_zero, at_one;

  assign ss_ev  = ss_in  & ~ss_prev;
  assign clr_ev = clr_in & ~clr_prev;

  // An ss edge in RUN freezes the prescaler where it is, so no step is taken that cycle.
  assign tick = (state == RUN) && !clr_ev && !ss_ev && (presc == PRE_LAST);

  assign all_zero = ({d3, d2, d1, d0} == 16'h0000);
  assign at_one   = ({d3, d2, d1, d0} == 16'h0001);

  // Counting down from 00:00 must not underflow; the tick only moves the FSM to DONE.
  assign step = tick && !(mode_down_q && all_zero);

  assign load_take  = load_in && ((state == IDLE) || (state == PAUSE)) && !clr_ev;
  assign load_apply = load_take && bcd_load_ok(load_val_i);

  bcd_digit_cnt u_sec_u (
    .clk(clk), .rst_n(rst_n), .clr(clr_ev), .step_en(step), .dir_down(mode_down_q),
    .max_val(BCD_MAX_UNIT), .load(load_apply), .load_val(load_val_i[3:0]), .dig(d0), .co(c0)
  );
  bcd_digit_cnt u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(clr_ev), .step_en(c0), .dir_down(mode_down_q),
    .max_val(BCD_MAX_TENS), .load(load_apply), .load_val(load_val_i[7:4]), .dig(d1), .co(c1)
  );
  bcd_digit_cnt u_min_u (
    .clk(clk), .rst_n(rst_n), .clr(clr_ev), .step_en(c1), .dir_down(mode_down_q),
    .max_val(BCD_MAX_UNIT), .load(load_apply), .load_val(load_val_i[11:8]), .dig(d2), .co(c2)
  );
  bcd_digit_cnt u_min_t (
    .clk(clk), .rst_n(rst_n), .clr(clr_ev), .step_en(c2), .dir_down(mode_down_q),
    .max_val(BCD_MAX_TENS), .load(load_apply), .load_val(load_val_i[15:12]), .dig(d3), .co(c3)
  );

  assign dig0_o = d0;
  assign dig1_o = d1;
  assign dig2_o = d2;
  assign dig3_o = d3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      mode_down_q <= 1'b0;
      ss_prev     <= 1'b0;
      clr_prev    <= 1'b0;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      wrap_o      <= 1'b0;
      load_err_o  <= 1'b0;
    end else begin
      ss_prev    <= ss_in;
      clr_prev   <= clr_in;
      load_err_o <= load_take && !load_apply;
      // Top-digit carry in up mode is exactly the 59:59 -> 00:00 rollover.
      wrap_o     <= c3 && !mode_down_q;
      if (state == IDLE) mode_down_q <= mode_down_i;

      if (clr_ev) begin
        state     <= IDLE;
        presc     <= '0;
        running_o <= 1'b0;
        done_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_ev) begin
              state     <= RUN;
              presc     <= '0;
              running_o <= 1'b1;
            end
          end
          RUN: begin
            if (ss_ev) begin
              state     <= PAUSE;
              running_o <= 1'b0;
            end else if (presc == PRE_LAST) begin
              presc <= '0;
              if (mode_down_q && (all_zero || at_one)) begin
                state     <= DONE;
                running_o <= 1'b0;
                done_o    <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            if (ss_ev) begin
              state     <= RUN;
              running_o <= 1'b1;
            end
          end
          default: ; // DONE waits for a clear
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_mmss_timer.sv
module tb_bcd_mmss_timer;

  localparam int TICK_DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_ss = 1'b0, btn_clr = 1'b0, mode_down = 1'b0, load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic        running, done, wrap, load_err;

  int checks = 0;
  int failures = 0;

  // Reference model: time kept as plain seconds 0..3599.
  int m_secs, m_state, m_pre;
  bit m_down, m_ssp, m_clrp, m_wrap, m_err;

  bcd_mmss_timer #(.TICK_DIV(TICK_DIV), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_ss_i(btn_ss), .btn_clr_i(btn_clr),
    .mode_down_i(mode_down), .load_i(load), .load_val_i(load_val),
    .dig0_o(dig0), .dig1_o(dig1), .dig2_o(dig2), .dig3_o(dig3),
    .running_o(running), .done_o(done), .wrap_o(wrap), .load_err_o(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sec2bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic bit preset_ok(input logic [15:0] v);
    return v[15:12] <= 5 && v[11:8] <= 9 && v[7:4] <= 5 && v[3:0] <= 9;
  endfunction

  function automatic int bcd2sec(input logic [15:0] v);
    return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_digits"}, {dig3, dig2, dig1, dig0}, sec2bcd(m_secs));
    chk({tag, "_running"}, 16'(running), 16'(m_state == S_RUN));
    chk({tag, "_done"}, 16'(done), 16'(m_state == S_DONE));
    chk({tag, "_wrap"}, 16'(wrap), 16'(m_wrap));
    chk({tag, "_load_err"}, 16'(load_err), 16'(m_err));
  endtask

  task automatic model_reset();
    m_secs = 0; m_state = S_IDLE; m_pre = 0; m_down = 0;
    m_ssp = 0; m_clrp = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step();
    if (m_down) begin
      if (m_secs <= 1) begin m_secs = 0; m_state = S_DONE; end
      else m_secs = m_secs - 1;
    end else begin
      if (m_secs == 3599) begin m_secs = 0; m_wrap = 1; end
      else m_secs = m_secs + 1;
    end
  endtask

  // Advance the model with the current inputs, clock once, compare everything.
  task automatic cyc(input string tag = "cyc");
    bit ss_ev, clr_ev;
    ss_ev  = btn_ss && !m_ssp;
    clr_ev = btn_clr && !m_clrp;
    m_wrap = 0; m_err = 0;
    if (m_state == S_IDLE) m_down = mode_down;
    if (clr_ev) begin
      m_secs = 0; m_pre = 0; m_state = S_IDLE;
    end else begin
      if (load && (m_state == S_IDLE || m_state == S_PAUSE)) begin
        if (preset_ok(load_val)) m_secs = bcd2sec(load_val);
        else m_err = 1;
      end
      case (m_state)
        S_IDLE:  if (ss_ev) begin m_state = S_RUN; m_pre = 0; end
        S_RUN: begin
          if (ss_ev) m_state = S_PAUSE;
          else if (m_pre == TICK_DIV - 1) begin m_pre = 0; model_step(); end
          else m_pre++;
        end
        S_PAUSE: if (ss_ev) m_state = S_RUN;
        default: ;
      endcase
    end
    m_ssp = btn_ss; m_clrp = btn_clr;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic pulse_ss();
    btn_ss = 1'b1; cyc("ss_pulse");
    btn_ss = 1'b0;
  endtask

  task automatic pulse_clr();
    btn_clr = 1'b1; cyc("clr_pulse");
    btn_clr = 1'b0; cyc("clr_rel");
  endtask

  initial begin
    // Reset state
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    // 1: count up from 00:00
    pulse_ss();
    chk("t1_running", 16'(running), 16'h1);
    repeat (4) cyc("t1");
    chk("t1_first_step", {dig3, dig2, dig1, dig0}, 16'h0001);
    repeat (156) cyc("t1");
    chk("t1_forty", {dig3, dig2, dig1, dig0}, 16'h0040);
    pulse_clr();

    // 2: wrap 59:58 -> 00:00
    mode_down = 1'b0; load = 1'b1; load_val = 16'h5958; cyc("t2_load");
    load = 1'b0;
    chk("t2_loaded", {dig3, dig2, dig1, dig0}, 16'h5958);
    pulse_ss();
    repeat (8) cyc("t2");
    chk("t2_wrap_hi", {15'h0, wrap}, 16'h1);
    chk("t2_zero", {dig3, dig2, dig1, dig0}, 16'h0000);
    cyc("t2");
    chk("t2_wrap_lo", {15'h0, wrap}, 16'h0);
    chk("t2_still_run", {15'h0, running}, 16'h1);
    pulse_clr();

    // 3: countdown to DONE
    mode_down = 1'b1; load = 1'b1; load_val = 16'h0002; cyc("t3_load");
    load = 1'b0;
    pulse_ss();
    repeat (4) cyc("t3");
    chk("t3_one", {dig3, dig2, dig1, dig0}, 16'h0001);
    repeat (4) cyc("t3");
    chk("t3_done", {14'h0, done, running}, 16'h0002);
    pulse_ss();
    repeat (6) cyc("t3_ign");
    chk("t3_ss_ignored", {15'h0, done}, 16'h1);
    pulse_clr();
    chk("t3_cleared", {14'h0, done, running}, 16'h0000);
    mode_down = 1'b0; cyc("t3");

    // 4: invalid presets
    load = 1'b1; load_val = 16'h6A00; cyc("t4_bad1");
    chk("t4_err1", {15'h0, load_err}, 16'h1);
    load = 1'b0; cyc("t4");
    load = 1'b1; load_val = 16'h6000; cyc("t4_bad2");
    chk("t4_err2", {15'h0, load_err}, 16'h1);
    load = 1'b0; cyc("t4");
    chk("t4_unchanged", {dig3, dig2, dig1, dig0}, 16'h0000);

    // 5: pause at 00:03 with prescaler at 2
    pulse_ss();
    repeat (14) cyc("t5");
    btn_ss = 1'b1; cyc("t5_pause"); btn_ss = 1'b0;
    repeat (20) cyc("t5_hold");
    chk("t5_held", {dig3, dig2, dig1, dig0}, 16'h0003);
    btn_ss = 1'b1; cyc("t5_resume"); btn_ss = 1'b0;
    cyc("t5");
    chk("t5_not_yet", {dig3, dig2, dig1, dig0}, 16'h0003);
    cyc("t5");
    chk("t5_four", {dig3, dig2, dig1, dig0}, 16'h0004);

    // 6: simultaneous clr+ss in RUN, then async reset mid-count
    repeat (3) cyc("t6");
    btn_ss = 1'b1; btn_clr = 1'b1; cyc("t6_clr_ss");
    chk("t6_idle", {14'h0, done, running}, 16'h0000);
    chk("t6_zero", {dig3, dig2, dig1, dig0}, 16'h0000);
    btn_ss = 1'b0; btn_clr = 1'b0; cyc("t6");
    pulse_ss();
    repeat (10) cyc("t6_run");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("t6_async_rst");
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 900; i++) begin
      btn_ss    = ($urandom_range(0, 7) == 0);
      btn_clr   = ($urandom_range(0, 39) == 0);
      load      = ($urandom_range(0, 9) == 0);
      mode_down = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0)
        load_val = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      else if ($urandom_range(0, 1) == 0)
        load_val = {12'h000, 4'($urandom_range(0, 3))};
      else
        load_val = 16'($urandom);
      cyc("rnd");
    end
    btn_ss = 1'b0; btn_clr = 1'b0; load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
